// File: rtl/icache_pkg.sv
// Shared types and address-field helpers for the direct-mapped instruction cache.
// Contents:
//   state_e     - cache controller states (idle lookup, line refill, replay bubble)
//   get_tag     - tag field of a byte address for a given index/offset width
//   get_index   - line index field of a byte address
//   get_offset  - word-within-line field of a byte address
package icache_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRefill,
        StReplay
    } state_e;

    // Byte-within-word bits; instruction fetches are always whole words.
    localparam int unsigned WordByteW = 2;

    function automatic logic [31:0] get_tag(input logic [31:0] addr,
                                            input int unsigned off_w,
                                            input int unsigned idx_w);
        return addr >> (WordByteW + off_w + idx_w);
    endfunction

    function automatic logic [31:0] get_index(input logic [31:0] addr,
                                              input int unsigned off_w,
                                              input int unsigned idx_w);
        return (addr >> (WordByteW + off_w)) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [31:0] get_offset(input logic [31:0] addr,
                                               input int unsigned off_w);
        return (addr >> WordByteW) & ((32'd1 << off_w) - 32'd1);
    endfunction

endpackage

// File: rtl/icache_if.sv
// Avalon-MM style read-only bus used on both sides of the instruction cache.
// Signals:
//   address     - byte address of the requested word
//   read        - read request, held while waitrequest is high
//   waitrequest - slave stall; a transfer completes when read=1 and waitrequest=0
//   readdata    - read data, valid in the completing cycle
// Modports: master drives address/read, slave drives waitrequest/readdata.
interface icache_if;

    logic [31:0] address;
    logic        read;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (
        output address,
        output read,
        input  waitrequest,
        input  readdata
    );

    modport slave (
        input  address,
        input  read,
        output waitrequest,
        output readdata
    );

endinterface

// File: rtl/icache_data_array.sv
// Data storage for the instruction cache: NUM_LINES x WORDS_PER_LINE words of 32 bits.
// Ports:
//   clk_i       - clock, write happens on the rising edge
//   we_i        - write enable
//   wr_line_i   - line index of the write
//   wr_word_i   - word within line of the write
//   wr_data_i   - write data
//   rd_line_i   - line index of the asynchronous read
//   rd_word_i   - word within line of the asynchronous read
//   rd_data_o   - read data (combinational)
module icache_data_array #(
    parameter int unsigned NUM_LINES      = 64,
    parameter int unsigned WORDS_PER_LINE = 4,
    localparam int unsigned IDX_W = $clog2(NUM_LINES),
    localparam int unsigned OFF_W = $clog2(WORDS_PER_LINE)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] wr_line_i,
    input  logic [OFF_W-1:0] wr_word_i,
    input  logic [31:0]      wr_data_i,
    input  logic [IDX_W-1:0] rd_line_i,
    input  logic [OFF_W-1:0] rd_word_i,
    output logic [31:0]      rd_data_o
);

    logic [31:0] mem_q [NUM_LINES*WORDS_PER_LINE];

    // Contents are only meaningful once the matching valid bit is set, so no reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[{wr_line_i, wr_word_i}] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[{rd_line_i, rd_word_i}];

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped, read-only instruction cache.
// Hits return data in the same cycle; a miss refills the whole line one word per memory
// transfer, spends one replay cycle, then looks the (possibly new) core address up again.
// Ports:
//   clk        - clock
//   reset      - synchronous active-high reset
//   flush      - one-cycle pulse, invalidates every line
//   core       - slave side of the core instruction bus
//   mem        - master side of the instruction memory bus
//   hit_count  - saturating count of hit transfers
//   miss_count - saturating count of refills started
module instr_cache
    import icache_pkg::*;
#(
    parameter int unsigned NUM_LINES      = 64,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    icache_if.slave     core,
    icache_if.master    mem,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int unsigned IDX_W = $clog2(NUM_LINES);
    localparam int unsigned OFF_W = $clog2(WORDS_PER_LINE);
    localparam int unsigned TAG_W = 32 - WordByteW - OFF_W - IDX_W;

    state_e           state_q;
    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q [NUM_LINES];
    logic [TAG_W-1:0] base_tag_q;
    logic [IDX_W-1:0] base_idx_q;
    logic [OFF_W-1:0] word_q;
    logic             flush_pending_q;
    logic             mem_read_q;
    logic [31:0]      mem_address_q;
    logic [31:0]      hit_q;
    logic [31:0]      miss_q;

    logic [TAG_W-1:0] lu_tag;
    logic [IDX_W-1:0] lu_idx;
    logic [OFF_W-1:0] lu_off;
    logic             lu_hit;
    logic             xfer_done;
    logic             last_word;
    logic [31:0]      rd_data;

    assign lu_tag = TAG_W'(get_tag(core.address, OFF_W, IDX_W));
    assign lu_idx = IDX_W'(get_index(core.address, OFF_W, IDX_W));
    assign lu_off = OFF_W'(get_offset(core.address, OFF_W));
    assign lu_hit = valid_q[lu_idx] && (tag_q[lu_idx] == lu_tag);

    // mem_read is always high in StRefill, so waitrequest low there completes a transfer.
    assign xfer_done = (state_q == StRefill) && !mem.waitrequest;
    assign last_word = (word_q == OFF_W'(WORDS_PER_LINE - 1));

    icache_data_array #(
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_data (
        .clk_i     (clk),
        .we_i      (xfer_done),
        .wr_line_i (base_idx_q),
        .wr_word_i (word_q),
        .wr_data_i (mem.readdata),
        .rd_line_i (lu_idx),
        .rd_word_i (lu_off),
        .rd_data_o (rd_data)
    );

    assign core.readdata    = rd_data;
    assign core.waitrequest = reset || (state_q != StIdle) || (core.read && !lu_hit);
    assign mem.read         = mem_read_q;
    assign mem.address      = mem_address_q;
    assign hit_count        = hit_q;
    assign miss_count       = miss_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            valid_q         <= '0;
            base_tag_q      <= '0;
            base_idx_q      <= '0;
            word_q          <= '0;
            flush_pending_q <= 1'b0;
            mem_read_q      <= 1'b0;
            mem_address_q   <= '0;
            hit_q           <= '0;
            miss_q          <= '0;
        end else begin
            // Lookups this cycle already used the old valid bits; clear takes effect next edge.
            if (flush) begin
                valid_q <= '0;
            end
            unique case (state_q)
                StIdle: begin
                    if (core.read) begin
                        if (lu_hit) begin
                            if (hit_q != '1) begin
                                hit_q <= hit_q + 32'd1;
                            end
                        end else begin
                            if (miss_q != '1) begin
                                miss_q <= miss_q + 32'd1;
                            end
                            base_tag_q    <= lu_tag;
                            base_idx_q    <= lu_idx;
                            word_q        <= '0;
                            mem_read_q    <= 1'b1;
                            mem_address_q <= {lu_tag, lu_idx, {OFF_W{1'b0}}, 2'b00};
                            state_q       <= StRefill;
                        end
                    end
                end
                StRefill: begin
                    if (flush) begin
                        flush_pending_q <= 1'b1;
                    end
                    // Address only advances on completion, keeping it stable across stalls.
                    if (!mem.waitrequest) begin
                        word_q        <= word_q + OFF_W'(1);
                        mem_address_q <= {base_tag_q, base_idx_q, word_q + OFF_W'(1), 2'b00};
                        if (last_word) begin
                            mem_read_q        <= 1'b0;
                            tag_q[base_idx_q] <= base_tag_q;
                            if (!flush_pending_q && !flush) begin
                                valid_q[base_idx_q] <= 1'b1;
                            end
                            state_q <= StReplay;
                        end
                    end
                end
                StReplay: begin
                    flush_pending_q <= 1'b0;
                    state_q         <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_cache.sv
// Self-checking bench for instr_cache: directed vector table, hand-written corner
// sequences (flush, redirect, reset mid-refill) and randomized reads with random memory
// stalls, all checked against a line-level reference model of the cache.
module tb_instr_cache;

    localparam int NL  = 64;
    localparam int WPL = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    icache_if core_bus ();
    icache_if mem_bus ();

    instr_cache #(
        .NUM_LINES      (NL),
        .WORDS_PER_LINE (WPL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .core       (core_bus),
        .mem        (mem_bus),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    // ---------------- memory responder ----------------
    int          stall_cycles = 0;
    bit          stall_random = 1'b0;
    int          stall_cnt    = 0;
    bit          held         = 1'b0;
    logic [31:0] held_addr;
    logic [31:0] mem_log [$];

    initial begin
        bit stall;
        mem_bus.waitrequest = 1'b0;
        mem_bus.readdata    = '0;
        forever begin
            @(negedge clk);
            if (mem_bus.read === 1'b1) begin
                if (held) check("mem_addr_stable", mem_bus.address, held_addr);
                mem_bus.readdata = mem_word(mem_bus.address);
                if (stall_random) stall = (stall_cnt < 8) && ($urandom_range(0, 2) != 0);
                else              stall = (stall_cnt < stall_cycles);
                if (stall) begin
                    mem_bus.waitrequest = 1'b1;
                    stall_cnt++;
                    held      = 1'b1;
                    held_addr = mem_bus.address;
                end else begin
                    mem_bus.waitrequest = 1'b0;
                    stall_cnt = 0;
                    held      = 1'b0;
                    mem_log.push_back(mem_bus.address);
                end
            end else begin
                mem_bus.waitrequest = 1'b0;
                stall_cnt = 0;
                held      = 1'b0;
            end
        end
    end

    // ---------------- reference model: which line base each index holds ----------------
    bit          ref_valid [NL];
    logic [31:0] ref_base  [NL];
    int unsigned ref_hits;
    int unsigned ref_misses;

    function automatic int idx_of(input logic [31:0] a);
        return int'((a / 32'(4 * WPL)) % 32'(NL));
    endfunction

    function automatic logic [31:0] base_of(input logic [31:0] a);
        return a - (a % 32'(4 * WPL));
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NL; i++) ref_valid[i] = 1'b0;
    endtask

    task automatic model_refill(input logic [31:0] a, input bit keep);
        ref_misses++;
        ref_valid[idx_of(a)] = keep;
        ref_base[idx_of(a)]  = base_of(a);
    endtask

    // A core read that ends in data: either a hit, or a refill then a replay hit.
    task automatic model_access(input logic [31:0] a, output bit hit);
        hit = ref_valid[idx_of(a)] && (ref_base[idx_of(a)] == base_of(a));
        if (!hit) model_refill(a, 1'b1);
        ref_hits++;
    endtask

    // ---------------- core-side drivers ----------------
    task automatic wait_data(output int cycles, output logic [31:0] data);
        cycles = 0;
        data   = '0;
        forever begin
            #1;
            if (core_bus.waitrequest === 1'b0) begin
                data = core_bus.readdata;
                break;
            end
            cycles++;
            if (cycles > 400) begin
                checks++;
                errors++;
                $display("FAIL core_timeout: waitrequest still high after %0d cycles", cycles);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic core_read(input logic [31:0] a, output int cycles, output logic [31:0] data);
        @(negedge clk);
        core_bus.address = a;
        core_bus.read    = 1'b1;
        wait_data(cycles, data);
    endtask

    task automatic check_refill_log(input logic [31:0] a, input int first);
        for (int k = 0; k < WPL; k++) begin
            if (first + k < mem_log.size())
                check("refill_addr", mem_log[first+k], base_of(a) + 32'(4 * k));
        end
    endtask

    // stall_fixed < 0 means random stalls, so only a lower bound on miss latency holds.
    task automatic access(input logic [31:0] a, input int stall_fixed, output int cyc);
        bit          hit;
        logic [31:0] d;
        mem_log.delete();
        model_access(a, hit);
        core_read(a, cyc, d);
        check("read_data", d, mem_word({a[31:2], 2'b00}));
        if (hit)                  check("hit_latency", 32'(cyc), 32'd0);
        else if (stall_fixed >= 0) check("miss_latency", 32'(cyc), 32'(2 + WPL * (1 + stall_fixed)));
        else                      check("miss_latency_min", 32'(cyc >= 2 + WPL), 32'd1);
        check("mem_xfers", 32'(mem_log.size()), hit ? 32'd0 : 32'(WPL));
        if (!hit) check_refill_log(a, 0);
        check("hit_count", hit_count, ref_hits);
        check("miss_count", miss_count, ref_misses);
    endtask

    typedef struct {
        logic [31:0] addr;
        bit          exp_hit;
        logic [31:0] exp_hits;
        logic [31:0] exp_misses;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int          cyc;
        bit          hit;
        logic [31:0] d;
        logic [31:0] a;

        vecs[0] = '{32'h0000_0000, 1'b0, 32'd1, 32'd1};  // cold miss
        vecs[1] = '{32'h0000_0004, 1'b1, 32'd2, 32'd1};
        vecs[2] = '{32'h0000_0008, 1'b1, 32'd3, 32'd1};
        vecs[3] = '{32'h0000_000C, 1'b1, 32'd4, 32'd1};
        vecs[4] = '{32'h0000_0400, 1'b0, 32'd5, 32'd2};  // same index, evicts 0x0
        vecs[5] = '{32'h0000_0000, 1'b0, 32'd6, 32'd3};
        vecs[6] = '{32'h0000_0404, 1'b0, 32'd7, 32'd4};

        core_bus.address = '0;
        core_bus.read    = 1'b0;
        flush            = 1'b0;
        reset            = 1'b1;
        model_clear();
        ref_hits   = 0;
        ref_misses = 0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_waitrequest", 32'(core_bus.waitrequest), 32'd1);
        check("rst_mem_read", 32'(mem_bus.read), 32'd0);
        check("rst_mem_address", mem_bus.address, 32'd0);
        check("rst_hit_count", hit_count, 32'd0);
        check("rst_miss_count", miss_count, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("idle_no_read_wait", 32'(core_bus.waitrequest), 32'd0);

        // Directed table: cold miss, back-to-back hits, conflict evictions.
        for (int i = 0; i < 7; i++) begin
            access(vecs[i].addr, 0, cyc);
            check("vec_hit", 32'(cyc == 0), 32'(vecs[i].exp_hit));
            check("vec_hits", hit_count, vecs[i].exp_hits);
            check("vec_misses", miss_count, vecs[i].exp_misses);
        end

        // Flush in idle: same-cycle lookup still hits, the next one misses.
        @(negedge clk);
        core_bus.address = 32'h0000_0404;
        core_bus.read    = 1'b1;
        flush            = 1'b1;
        #1;
        check("flush_same_cycle_wait", 32'(core_bus.waitrequest), 32'd0);
        check("flush_same_cycle_data", core_bus.readdata, mem_word(32'h0000_0404));
        ref_hits++;
        model_clear();
        mem_log.delete();
        @(negedge clk);
        flush = 1'b0;
        model_access(32'h0000_0404, hit);
        wait_data(cyc, d);
        check("post_flush_latency", 32'(cyc), 32'd6);
        check("post_flush_data", d, mem_word(32'h0000_0404));
        check("post_flush_hits", hit_count, ref_hits);
        check("post_flush_misses", miss_count, ref_misses);

        // Memory stalls of 3 cycles per word.
        stall_cycles = 3;
        access(32'h0000_0800, 3, cyc);
        stall_cycles = 0;

        // Redirect mid-refill: 0x0 line completes, then 0x80 misses and refills.
        mem_log.delete();
        @(negedge clk);
        core_bus.address = 32'h0000_0000;
        repeat (2) @(negedge clk);
        core_bus.address = 32'h0000_0080;
        model_refill(32'h0000_0000, 1'b1);
        model_access(32'h0000_0080, hit);
        wait_data(cyc, d);
        check("redirect_latency", 32'(cyc), 32'd10);
        check("redirect_data", d, mem_word(32'h0000_0080));
        check("redirect_xfers", 32'(mem_log.size()), 32'(2 * WPL));
        check_refill_log(32'h0000_0000, 0);
        check_refill_log(32'h0000_0080, WPL);
        check("redirect_misses", miss_count, ref_misses);
        access(32'h0000_0008, 0, cyc);  // line 0x0 must have been kept

        // Flush during refill at word 2: line stays invalid.
        mem_log.delete();
        @(negedge clk);
        core_bus.address = 32'h0000_1000;
        repeat (3) @(negedge clk);
        flush         = 1'b1;
        core_bus.read = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        repeat (4) @(negedge clk);
        check("flush_refill_xfers", 32'(mem_log.size()), 32'(WPL));
        model_refill(32'h0000_1000, 1'b0);
        model_clear();
        check("flush_refill_misses", miss_count, ref_misses);
        access(32'h0000_1000, 0, cyc);
        access(32'h0000_0080, 0, cyc);

        // Reset in the middle of a refill.
        @(negedge clk);
        core_bus.address = 32'h0000_2000;
        core_bus.read    = 1'b1;
        repeat (2) @(negedge clk);
        reset         = 1'b1;
        core_bus.read = 1'b0;
        #1;
        check("mid_rst_waitrequest", 32'(core_bus.waitrequest), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_mem_read", 32'(mem_bus.read), 32'd0);
        check("mid_rst_hit_count", hit_count, 32'd0);
        check("mid_rst_miss_count", miss_count, 32'd0);
        check("mid_rst_idle_wait", 32'(core_bus.waitrequest), 32'd0);
        model_clear();
        ref_hits   = 0;
        ref_misses = 0;
        access(32'h0000_1000, 0, cyc);

        // Random reads, random memory stalls, occasional idle flushes.
        stall_random = 1'b1;
        for (int n = 0; n < 150; n++) begin
            a = 32'($urandom_range(0, 32'h1FFF));
            if ($urandom_range(0, 7) == 0) a[31:24] = 8'($urandom_range(0, 255));
            access(a, -1, cyc);
            if ($urandom_range(0, 19) == 0) begin
                @(negedge clk);
                core_bus.read = 1'b0;
                flush         = 1'b1;
                @(negedge clk);
                flush = 1'b0;
                model_clear();
            end
        end
        stall_random = 1'b0;

        @(negedge clk);
        core_bus.read = 1'b0;
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
